layer_seq: RTL and testbench

- Sequences one feature-map pass through the CNN datapath: conv engine → in-place ReLU → pool, using start/done pulse handshakes.
- Owns the shared CONV buffer ports. Port A (read) and port B (write) go to whichever stage is active; all other clients are gated off.
- Sits between the top-level inference controller and the conv/relu/pool engines.
- Adds a per-stage watchdog, an abort input and an optional ReLU bypass.

---
 rtl/layer_seq.sv | 169 ++++++++++++++++
 tb/tb_layer_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq.sv
// Sequences one feature-map pass: conv -> optional in-place ReLU -> pool.
// Also owns the shared CONV buffer ports and runs a per-stage watchdog.
module layer_seq #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            stage,
  output logic                  conv_start,
  output logic                  relu_start,
  output logic                  pool_start,
  input  logic                  conv_done,
  input  logic                  relu_done,
  input  logic                  pool_done,
  input  logic [ADDR_WIDTH-1:0] conv_w_addr,
  input  logic                  conv_w_en,
  input  logic                  conv_w_we,
  input  logic [DATA_WIDTH-1:0] conv_w_d,
  input  logic [ADDR_WIDTH-1:0] relu_r_addr,
  input  logic                  relu_r_en,
  input  logic [ADDR_WIDTH-1:0] relu_w_addr,
  input  logic                  relu_w_en,
  input  logic                  relu_w_we,
  input  logic [DATA_WIDTH-1:0] relu_w_d,
  input  logic [ADDR_WIDTH-1:0] pool_r_addr,
  input  logic                  pool_r_en,
  output logic [ADDR_WIDTH-1:0] buf_r_addr,
  output logic                  buf_r_en,
  output logic [ADDR_WIDTH-1:0] buf_w_addr,
  output logic                  buf_w_en,
  output logic                  buf_w_we,
  output logic [DATA_WIDTH-1:0] buf_w_d,
  output logic [DATA_WIDTH-1:0] relu_r_q,
  output logic [DATA_WIDTH-1:0] pool_r_q,
  input  logic [DATA_WIDTH-1:0] buf_r_q
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_RELU, S_POOL, S_DONE, S_ERR
  } state_t;

  state_t          state, state_d;
  logic            relu_on, relu_on_d;
  logic [CW-1:0]   wd_cnt, wd_cnt_d;
  logic            active, timeout;
  logic            busy_d, done_d, error_d;
  logic            conv_start_d, relu_start_d, pool_start_d;
  logic [1:0]      stage_d;

  // Next state, watchdog and the values the output flops take on the next edge
  always_comb begin
    state_d      = state;
    relu_on_d    = relu_on;
    active       = (state == S_CONV) || (state == S_RELU) || (state == S_POOL);
    timeout      = active && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    case (state)
      S_IDLE: if (start && !abort) begin
        state_d   = S_CONV;
        relu_on_d = relu_en;
      end
      S_CONV: begin
        if (abort)          state_d = S_IDLE;
        else if (conv_done) state_d = relu_on ? S_RELU : S_POOL;
        else if (timeout)   state_d = S_ERR;
      end
      S_RELU: begin
        if (abort)          state_d = S_IDLE;
        else if (relu_done) state_d = S_POOL;
        else if (timeout)   state_d = S_ERR;
      end
      S_POOL: begin
        if (abort)          state_d = S_IDLE;
        else if (pool_done) state_d = S_DONE;
        else if (timeout)   state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every stage entry and idles at zero outside stages
    if (state_d != state || !active) wd_cnt_d = '0;
    else                             wd_cnt_d = wd_cnt + CW'(1);

    busy_d       = (state_d == S_CONV) || (state_d == S_RELU) || (state_d == S_POOL);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    conv_start_d = (state_d == S_CONV) && (state != S_CONV);
    relu_start_d = (state_d == S_RELU) && (state != S_RELU);
    pool_start_d = (state_d == S_POOL) && (state != S_POOL);
    case (state_d)
      S_CONV:  stage_d = 2'd1;
      S_RELU:  stage_d = 2'd2;
      S_POOL:  stage_d = 2'd3;
      default: stage_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      relu_on    <= 1'b0;
      wd_cnt     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      stage      <= 2'd0;
      conv_start <= 1'b0;
      relu_start <= 1'b0;
      pool_start <= 1'b0;
    end else begin
      state      <= state_d;
      relu_on    <= relu_on_d;
      wd_cnt     <= wd_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      stage      <= stage_d;
      conv_start <= conv_start_d;
      relu_start <= relu_start_d;
      pool_start <= pool_start_d;
    end
  end

  // Buffer port grant follows the registered state; non-owners are gated to zero
  always_comb begin
    buf_r_addr = '0;
    buf_r_en   = 1'b0;
    buf_w_addr = '0;
    buf_w_en   = 1'b0;
    buf_w_we   = 1'b0;
    buf_w_d    = '0;
    case (state)
      S_CONV: begin
        buf_w_addr = conv_w_addr;
        buf_w_en   = conv_w_en;
        buf_w_we   = conv_w_we;
        buf_w_d    = conv_w_d;
      end
      S_RELU: begin
        buf_r_addr = relu_r_addr;
        buf_r_en   = relu_r_en;
        buf_w_addr = relu_w_addr;
        buf_w_en   = relu_w_en;
        buf_w_we   = relu_w_we;
        buf_w_d    = relu_w_d;
      end
      S_POOL: begin
        buf_r_addr = pool_r_addr;
        buf_r_en   = pool_r_en;
      end
      default: ;
    endcase
  end

  assign relu_r_q = buf_r_q;
  assign pool_r_q = buf_r_q;

endmodule

// File: tb/tb_layer_seq.sv
// Randomized directed passes through layer_seq, checked every cycle against a
// stage-timeline model and a shadow copy of the CONV buffer.
module tb_layer_seq;
  localparam int TO   = 50;
  localparam int MAXC = 200;

  logic        clk = 1'b0;
  logic        reset, start, abort, relu_en;
  logic        busy, done, error;
  logic [1:0]  stage;
  logic        conv_start, relu_start, pool_start;
  logic        conv_done, relu_done, pool_done;
  logic [5:0]  conv_w_addr, relu_r_addr, relu_w_addr, pool_r_addr;
  logic        conv_w_en, conv_w_we, relu_r_en, relu_w_en, relu_w_we, pool_r_en;
  logic [15:0] conv_w_d, relu_w_d;
  logic [5:0]  buf_r_addr, buf_w_addr;
  logic        buf_r_en, buf_w_en, buf_w_we;
  logic [15:0] buf_w_d, relu_r_q, pool_r_q;
  logic [15:0] buf_r_q = 16'd0;

  logic [15:0] mem [64];
  logic [15:0] ref_mem [64];
  logic        seed = 1'b0;

  // Model timeline: 0 idle, 1 conv, 2 relu, 3 pool, 4 done, 5 err
  int exst [MAXC];
  int dsched [MAXC];
  int vectors = 0;
  int miscompares = 0;

  layer_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .relu_en(relu_en),
    .busy(busy), .done(done), .error(error), .stage(stage),
    .conv_start(conv_start), .relu_start(relu_start), .pool_start(pool_start),
    .conv_done(conv_done), .relu_done(relu_done), .pool_done(pool_done),
    .conv_w_addr(conv_w_addr), .conv_w_en(conv_w_en), .conv_w_we(conv_w_we), .conv_w_d(conv_w_d),
    .relu_r_addr(relu_r_addr), .relu_r_en(relu_r_en), .relu_w_addr(relu_w_addr),
    .relu_w_en(relu_w_en), .relu_w_we(relu_w_we), .relu_w_d(relu_w_d),
    .pool_r_addr(pool_r_addr), .pool_r_en(pool_r_en),
    .buf_r_addr(buf_r_addr), .buf_r_en(buf_r_en),
    .buf_w_addr(buf_w_addr), .buf_w_en(buf_w_en), .buf_w_we(buf_w_we), .buf_w_d(buf_w_d),
    .relu_r_q(relu_r_q), .pool_r_q(pool_r_q), .buf_r_q(buf_r_q)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed_val(input int i);
    if (i % 3 == 0) return 16'(-i);
    if (i % 3 == 1) return 16'd0;
    return 16'(i);
  endfunction

  // Buffer memory behind ports A/B, one-cycle read latency
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_val(i);
    end else if (buf_w_en && buf_w_we) begin
      mem[buf_w_addr] <= buf_w_d;
    end
    if (buf_r_en) buf_r_q <= mem[buf_r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stage"}, 32'(stage), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".error"}, 32'(error), 0);
    chk({tag, ".starts"}, 32'({conv_start, relu_start, pool_start}), 0);
    chk({tag, ".buf_r"}, 32'({buf_r_en, buf_r_addr}), 0);
    chk({tag, ".buf_w"}, 32'({buf_w_en, buf_w_we, buf_w_addr, buf_w_d}), 0);
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; relu_en = 0;
    conv_done = 0; relu_done = 0; pool_done = 0;
    conv_w_addr = 0; conv_w_en = 0; conv_w_we = 0; conv_w_d = 0;
    relu_r_addr = 0; relu_r_en = 0; relu_w_addr = 0; relu_w_en = 0; relu_w_we = 0; relu_w_d = 0;
    pool_r_addr = 0; pool_r_en = 0;
  endtask

  // Lay out the expected stage timeline; d >= TO means that done is withheld
  task automatic build(input bit relu, input int dc, input int dr, input int dp, input int ab);
    int seq [3];
    int nst, t, d, len, lim;
    for (int c = 0; c < MAXC; c++) begin exst[c] = 0; dsched[c] = 0; end
    if (ab == 0) return;
    seq[0] = 1; nst = 1;
    if (relu) begin seq[nst] = 2; nst++; end
    seq[nst] = 3; nst++;
    t = 1;
    for (int k = 0; k < nst; k++) begin
      d   = (seq[k] == 1) ? dc : (seq[k] == 2) ? dr : dp;
      len = (d < TO) ? d + 1 : TO;
      lim = (ab >= t && ab < t + len) ? ab : t + len - 1;
      for (int c = t; c <= lim; c++) exst[c] = seq[k];
      if (d < TO && t + d <= lim) dsched[t + d] = seq[k];
      if (lim == ab) return;
      if (d >= TO) begin
        for (int c = t + TO; c < MAXC; c++) if (ab < 0 || c <= ab) exst[c] = 5;
        return;
      end
      t += len;
    end
    exst[t] = 4;
  endtask

  // mode: 0 random client traffic, 1 every client enabled on distinct addresses, 2 conv never writes
  task automatic drive_clients(input int mode);
    conv_w_d = 16'($urandom);
    relu_w_d = 16'($urandom);
    if (mode == 1) begin
      conv_w_addr = 6'd5;  relu_r_addr = 6'd17; relu_w_addr = 6'd33; pool_r_addr = 6'd49;
      conv_w_en = 1; conv_w_we = 1; relu_r_en = 1; relu_w_en = 1; relu_w_we = 1; pool_r_en = 1;
    end else begin
      conv_w_addr = 6'($urandom); relu_r_addr = 6'($urandom);
      relu_w_addr = 6'($urandom); pool_r_addr = 6'($urandom);
      conv_w_en = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      conv_w_we = 1'($urandom_range(0, 1));
      relu_r_en = 1'($urandom_range(0, 1));
      relu_w_en = 1'($urandom_range(0, 1));
      relu_w_we = 1'($urandom_range(0, 1));
      pool_r_en = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_pass(input bit relu, input int dc, input int dr, input int dp,
                          input int ab, input int n, input int mode);
    int st, sg, prev, bad;
    build(relu, dc, dr, dp, ab);
    prev = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      st = exst[c];
      sg = (st >= 1 && st <= 3) ? st : 0;
      chk("stage", 32'(stage), 32'(sg));
      chk("busy", 32'(busy), 32'(sg != 0));
      chk("done", 32'(done), 32'(st == 4));
      chk("error", 32'(error), 32'(st == 5));
      chk("conv_start", 32'(conv_start), 32'(st == 1 && prev != 1));
      chk("relu_start", 32'(relu_start), 32'(st == 2 && prev != 2));
      chk("pool_start", 32'(pool_start), 32'(st == 3 && prev != 3));
      prev = st;
      // Inputs for this cycle; start and foreign dones are noise the DUT must ignore
      start     = (c == 0) ? 1'b1 : (st == 0) ? 1'b0 : (st == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      abort     = (c == ab);
      relu_en   = (c == 0) ? relu : 1'($urandom_range(0, 1));
      conv_done = (st == 1) ? (dsched[c] == 1) : 1'($urandom_range(0, 1));
      relu_done = (st == 2) ? (dsched[c] == 2) : 1'($urandom_range(0, 1));
      pool_done = (st == 3) ? (dsched[c] == 3) : 1'($urandom_range(0, 1));
      drive_clients(mode);
      #1;
      chk("buf_r_en", 32'(buf_r_en), 32'((sg == 2) ? relu_r_en : (sg == 3) ? pool_r_en : 1'b0));
      chk("buf_r_addr", 32'(buf_r_addr), 32'((sg == 2) ? relu_r_addr : (sg == 3) ? pool_r_addr : 6'd0));
      chk("buf_w_en", 32'(buf_w_en), 32'((sg == 1) ? conv_w_en : (sg == 2) ? relu_w_en : 1'b0));
      chk("buf_w_we", 32'(buf_w_we), 32'((sg == 1) ? conv_w_we : (sg == 2) ? relu_w_we : 1'b0));
      chk("buf_w_addr", 32'(buf_w_addr), 32'((sg == 1) ? conv_w_addr : (sg == 2) ? relu_w_addr : 6'd0));
      chk("buf_w_d", 32'(buf_w_d), 32'((sg == 1) ? conv_w_d : (sg == 2) ? relu_w_d : 16'd0));
      chk("rd_fanout", 32'({relu_r_q, pool_r_q}), 32'({buf_r_q, buf_r_q}));
      if (sg == 1 && conv_w_en && conv_w_we) ref_mem[conv_w_addr] = conv_w_d;
      if (sg == 2 && relu_w_en && relu_w_we) ref_mem[relu_w_addr] = relu_w_d;
    end
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("buffer", 32'(bad), 0);
  endtask

  int dc, dr, dp, ab, bad;
  bit rl;

  initial begin
    reset = 1'b0;
    clear_inputs();
    #3;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    seed = 1'b1;
    @(posedge clk);
    #1 seed = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_val(i);

    run_pass(1, 10, 10, 10, -1, MAXC, 0);         // starts at 1, 12, 23; done at 34
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_val(i);
    seed = 1'b1;
    @(posedge clk);
    #1 seed = 1'b0;
    run_pass(0, 10, 10, 10, -1, MAXC, 2);         // bypass leaves seeded buffer untouched
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== seed_val(i)) bad++;
    chk("seed_kept", 32'(bad), 0);
    run_pass(1, 7, 9, 11, -1, MAXC, 1);           // grant isolation
    run_pass(0, 12, 0, 8, -1, MAXC, 1);
    run_pass(1, 5, TO, 5, 170, MAXC, 0);          // relu watchdog, start ignored in ERR
    run_pass(1, TO - 1, TO - 1, TO - 1, -1, MAXC, 0); // done on the limit cycle wins
    run_pass(0, TO, 5, 5, 170, MAXC, 0);          // conv watchdog
    run_pass(1, 2, 2, TO, 170, MAXC, 0);          // pool watchdog
    run_pass(1, 10, 10, 10, 11, MAXC, 0);         // abort together with conv_done
    run_pass(1, 10, 10, 10, -1, MAXC, 0);
    run_pass(1, 5, 5, 5, 0, MAXC, 0);             // abort beats start in IDLE
    run_pass(1, 5, 20, 5, 15, MAXC, 0);           // abort mid relu

    for (int k = 0; k < 8; k++) begin
      rl = 1'($urandom_range(0, 1));
      dc = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, TO - 1));
      dr = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, TO - 1));
      dp = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, TO - 1));
      if (dc >= TO || (rl && dr >= TO) || dp >= TO) ab = 170;
      else ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1;
      run_pass(rl, dc, dr, dp, ab, MAXC, 0);
    end

    // Asynchronous reset while in POOL (pool entered at cycle 9)
    run_pass(1, 3, 3, 30, -1, 15, 0);
    #1 reset = 1'b0;
    #1 chk_zero("async_reset");
    clear_inputs();
    @(negedge clk);
    chk_zero("in_reset");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_done", 32'(done), 0);
    end
    run_pass(1, 4, 6, 8, -1, MAXC, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
